// File: rtl/gshare_param_predictor.sv
// Gshare branch predictor: PC xor global history indexes a table of 2-bit counters.
// After reset the table is swept to CNT_INIT, one entry per cycle, before ready rises.
module gshare_param_predictor #(
  parameter int unsigned HIST_BITS = 7,
  parameter int unsigned PC_BITS   = 7,
  parameter logic [1:0]  CNT_INIT  = 2'b01
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 ready,
  input  logic                 predict_valid,
  input  logic [PC_BITS-1:0]   predict_pc,
  output logic                 predict_taken,
  output logic [HIST_BITS-1:0] predict_history,
  input  logic                 train_valid,
  input  logic                 train_taken,
  input  logic                 train_mispredicted,
  input  logic [HIST_BITS-1:0] train_history,
  input  logic [PC_BITS-1:0]   train_pc,
  output logic [15:0]          mispredict_count
);

  localparam int unsigned NUM_ENTRIES = 1 << HIST_BITS;
  localparam int unsigned CNT_W       = 16;

  typedef enum logic {INIT, RUN} state_t;

  state_t                 state_q, state_d;
  logic [HIST_BITS-1:0]   sweep_q;
  logic [HIST_BITS-1:0]   ghr_q;
  logic [CNT_W-1:0]       miss_cnt_q;
  logic [1:0]             pht [NUM_ENTRIES];

  logic [HIST_BITS-1:0]   pred_idx;
  logic [HIST_BITS-1:0]   train_idx;
  logic [1:0]             train_cnt;
  logic [1:0]             train_cnt_next;
  logic                   run;
  logic                   recover;

  assign run       = (state_q == RUN);
  assign pred_idx  = predict_pc[HIST_BITS-1:0] ^ ghr_q;
  assign train_idx = train_pc[HIST_BITS-1:0] ^ train_history;
  assign recover   = run && train_valid && train_mispredicted;

  assign ready            = run;
  assign predict_taken    = run && pht[pred_idx][1];
  assign predict_history  = ghr_q;
  assign mispredict_count = miss_cnt_q;

  // Next state: leave INIT once the last table entry has been written.
  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT: if (sweep_q == HIST_BITS'(NUM_ENTRIES - 1)) state_d = RUN;
      RUN:  state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  // Saturating 2-bit counter update for the trained entry.
  always_comb begin
    train_cnt      = pht[train_idx];
    train_cnt_next = train_cnt;
    if (train_taken) begin
      if (train_cnt != 2'd3) train_cnt_next = train_cnt + 2'd1;
    end else begin
      if (train_cnt != 2'd0) train_cnt_next = train_cnt - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= INIT;
      sweep_q    <= '0;
      ghr_q      <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (!run) sweep_q <= sweep_q + HIST_BITS'(1);
      // Mispredict recovery takes priority over the speculative shift.
      if (recover) begin
        ghr_q <= {train_history[HIST_BITS-2:0], train_taken};
      end else if (run && predict_valid) begin
        ghr_q <= {ghr_q[HIST_BITS-2:0], predict_taken};
      end
      if (recover && (miss_cnt_q != {CNT_W{1'b1}})) miss_cnt_q <= miss_cnt_q + CNT_W'(1);
    end
  end

  // Table storage has no reset; contents become valid through the INIT sweep.
  always_ff @(posedge clk) begin
    if (!run) begin
      pht[sweep_q] <= CNT_INIT;
    end else if (train_valid) begin
      pht[train_idx] <= train_cnt_next;
    end
  end

endmodule

// File: tb/tb_gshare_param_predictor.sv
// Scoreboard bench for gshare_param_predictor at default parameters.
module tb_gshare_param_predictor;

  localparam int unsigned HB = 7;
  localparam int unsigned PB = 7;
  localparam int unsigned N  = 1 << HB;

  logic          clk = 1'b0;
  logic          rst;
  logic          ready;
  logic          predict_valid;
  logic [PB-1:0] predict_pc;
  logic          predict_taken;
  logic [HB-1:0] predict_history;
  logic          train_valid;
  logic          train_taken;
  logic          train_mispredicted;
  logic [HB-1:0] train_history;
  logic [PB-1:0] train_pc;
  logic [15:0]   mispredict_count;

  gshare_param_predictor #(.HIST_BITS(HB), .PC_BITS(PB), .CNT_INIT(2'b01)) dut (
    .clk                (clk),
    .rst                (rst),
    .ready              (ready),
    .predict_valid      (predict_valid),
    .predict_pc         (predict_pc),
    .predict_taken      (predict_taken),
    .predict_history    (predict_history),
    .train_valid        (train_valid),
    .train_taken        (train_taken),
    .train_mispredicted (train_mispredicted),
    .train_history      (train_history),
    .train_pc           (train_pc),
    .mispredict_count   (mispredict_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_entry_t;

  sb_entry_t     sb [$];
  int            n_vec = 0;
  int            n_err = 0;

  logic [1:0]    pht_m [N];
  logic [HB-1:0] ghr_m;
  logic [15:0]   cnt_m;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] exp);
    sb_entry_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic sb_pop_check(input logic [31:0] got);
    sb_entry_t e;
    if (sb.size() == 0) begin
      check_val("sb_empty", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      check_val(e.tag, got, e.exp);
    end
  endtask

  task automatic drive_idle();
    predict_valid      = 1'b0;
    predict_pc         = '0;
    train_valid        = 1'b0;
    train_taken        = 1'b0;
    train_mispredicted = 1'b0;
    train_history      = '0;
    train_pc           = '0;
  endtask

  // Reset, then count edges until ready while hammering the inputs to prove they are ignored.
  task automatic reset_and_init(input int pre_abort);
    int cyc;
    @(negedge clk);
    rst                = 1'b1;
    predict_valid      = 1'b1;
    predict_pc         = 7'h33;
    train_valid        = 1'b1;
    train_taken        = 1'b1;
    train_mispredicted = 1'b1;
    train_history      = 7'h55;
    train_pc           = 7'h12;
    #1;
    sb_push("rst_ready", 32'd0);
    sb_pop_check(32'(ready));
    sb_push("rst_count", 32'd0);
    sb_pop_check(32'(mispredict_count));
    @(negedge clk);
    rst = 1'b0;
    if (pre_abort > 0) begin
      repeat (pre_abort) @(posedge clk);
      #1;
      sb_push("abort_ready", 32'd0);
      sb_pop_check(32'(ready));
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
    end
    cyc = 0;
    while (cyc < 300) begin
      #1;
      if (predict_taken !== 1'b0 || predict_history !== '0)
        check_val("init_outputs", {predict_taken, 24'd0, predict_history}, 32'd0);
      @(posedge clk);
      #1;
      cyc++;
      if (ready === 1'b1) break;
    end
    check_val("init_length", 32'(cyc), 32'(N));
    check_val("init_count", 32'(mispredict_count), 32'd0);
    check_val("init_hist", 32'(predict_history), 32'd0);
    drive_idle();
    for (int i = 0; i < int'(N); i++) pht_m[i] = 2'b01;
    ghr_m = '0;
    cnt_m = '0;
  endtask

  // One RUN cycle: predict-side expectations before the edge, state expectations after it.
  task automatic run_cycle(input logic pv, input logic [PB-1:0] ppc,
                           input logic tv, input logic tt, input logic tm,
                           input logic [HB-1:0] th, input logic [PB-1:0] tpc);
    int   pidx, tidx;
    logic pt;
    @(negedge clk);
    predict_valid      = pv;
    predict_pc         = ppc;
    train_valid        = tv;
    train_taken        = tt;
    train_mispredicted = tm;
    train_history      = th;
    train_pc           = tpc;
    #1;
    pidx = int'(ppc[HB-1:0] ^ ghr_m);
    tidx = int'(tpc[HB-1:0] ^ th);
    pt   = pht_m[pidx][1];
    sb_push("predict_taken", 32'(pt));
    sb_push("predict_history", 32'(ghr_m));
    sb_pop_check(32'(predict_taken));
    sb_pop_check(32'(predict_history));
    if (tv) begin
      if (tt && pht_m[tidx] != 2'd3) pht_m[tidx] = pht_m[tidx] + 2'd1;
      else if (!tt && pht_m[tidx] != 2'd0) pht_m[tidx] = pht_m[tidx] - 2'd1;
    end
    if (tv && tm) begin
      ghr_m = {th[HB-2:0], tt};
      if (cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
    end else if (pv) begin
      ghr_m = {ghr_m[HB-2:0], pt};
    end
    @(posedge clk);
    #1;
    sb_push("mispredict_count", 32'(cnt_m));
    sb_pop_check(32'(mispredict_count));
    sb_push("ready", 32'd1);
    sb_pop_check(32'(ready));
  endtask

  function automatic logic [PB-1:0] pc_for(input int idx);
    return PB'(idx) ^ ghr_m;
  endfunction

  initial begin
    rst = 1'b1;
    drive_idle();
    reset_and_init(0);

    // Predict pc 10, then mispredict-train pc 10 with history 0.
    run_cycle(1'b1, 7'd10, 1'b0, 1'b0, 1'b0, 7'd0, 7'd0);
    run_cycle(1'b0, 7'd0,  1'b1, 1'b1, 1'b1, 7'd0, 7'd10);
    check_val("pht10_after", 32'(pht_m[10]), 32'd2);
    // pc 11 with GHR 1 hits index 10: taken, history 1, GHR becomes 3.
    run_cycle(1'b1, 7'd11, 1'b0, 1'b0, 1'b0, 7'd0, 7'd0);
    run_cycle(1'b0, 7'd0,  1'b0, 1'b0, 1'b0, 7'd0, 7'd0);

    // Saturate index 5 then step down once; prediction stays taken.
    repeat (4) run_cycle(1'b0, 7'd0, 1'b1, 1'b1, 1'b0, 7'd0, 7'd5);
    run_cycle(1'b0, 7'd0, 1'b1, 1'b0, 1'b0, 7'd0, 7'd5);
    run_cycle(1'b0, pc_for(5), 1'b0, 1'b0, 1'b0, 7'd0, 7'd0);

    // Taken predict on index 5 with same-cycle recovery: recovery wins (GHR 0x2A).
    run_cycle(1'b1, pc_for(5), 1'b1, 1'b0, 1'b1, 7'h15, 7'h20);
    run_cycle(1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 7'd0, 7'd0);

    // Same index predicted and trained down in one cycle: read sees the old counter.
    run_cycle(1'b1, pc_for(10), 1'b1, 1'b0, 1'b0, ghr_m, pc_for(10));
    run_cycle(1'b1, pc_for(10), 1'b1, 1'b0, 1'b0, ghr_m, pc_for(10));

    // train_mispredicted without train_valid must do nothing.
    run_cycle(1'b0, 7'd0, 1'b0, 1'b1, 1'b1, 7'h7F, 7'd3);

    // Random traffic against the model.
    for (int i = 0; i < 300; i++) begin
      run_cycle(1'($urandom), PB'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom_range(0, 3) == 0), HB'($urandom), PB'($urandom));
    end

    // Reset mid-RUN, then abort INIT after 50 cycles; full sweep must restart.
    reset_and_init(50);
    run_cycle(1'b1, 7'd10, 1'b0, 1'b0, 1'b0, 7'd0, 7'd0);
    for (int i = 0; i < 40; i++) begin
      run_cycle(1'($urandom), PB'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), HB'($urandom), PB'($urandom));
    end

    check_val("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gshare_param_predictor.md
GSHARE_PARAM_PREDICTOR -- requirements
Module: gshare_param_predictor

Interface
REQ-001 Parameter HIST_BITS, default 7: global history width; the pattern history table (PHT) has 2^HIST_BITS entries.
REQ-002 Parameter PC_BITS, default 7: branch PC width; PC_BITS >= HIST_BITS is required.
REQ-003 Parameter CNT_INIT, default 2'b01: PHT counter value written during initialisation (weakly not-taken).
REQ-004 Reset is asynchronous and active-high. The block has one clock.
REQ-005 Port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-006 Port rst, input, 1: asynchronous, active-high reset.
REQ-007 Port ready, output, 1: high once PHT initialisation is complete.
REQ-008 Port predict_valid, input, 1: a prediction is consumed this cycle.
REQ-009 Port predict_pc, input, PC_BITS: PC of the branch being predicted.
REQ-010 Port predict_taken, output, 1: combinational prediction.
REQ-011 Port predict_history, output, HIST_BITS: GHR value used for this prediction; the requester saves it for training.
REQ-012 Port train_valid, input, 1: a resolved branch is presented this cycle.
REQ-013 Port train_taken, input, 1: actual branch outcome.
REQ-014 Port train_mispredicted, input, 1: the earlier prediction was wrong.
REQ-015 Port train_history, input, HIST_BITS: the predict_history value saved at prediction time.
REQ-016 Port train_pc, input, PC_BITS: PC of the resolved branch.
REQ-017 Port mispredict_count, output, 16: saturating count of accepted mispredict trainings.

Function
REQ-018 Index: idx = PC[HIST_BITS-1:0] XOR history. Prediction uses predict_pc with the GHR; training uses train_pc with train_history.
REQ-019 PHT entries are 2-bit saturating counters; predict_taken = PHT[idx][1], read combinationally.
REQ-020 The FSM has two states. INIT: sweep counter writes CNT_INIT to entry 0, 1, ..., 2^HIST_BITS-1, one entry per cycle. After the last write, INIT goes to RUN. RUN: normal operation.
REQ-021 ready = 1 only in RUN; initialisation takes exactly 2^HIST_BITS cycles after rst deasserts.
REQ-022 In INIT: predict_valid and train_valid are ignored, predict_taken = 0, and GHR holds 0.
REQ-023 predict_history = current GHR, combinational; this is the pre-update value.
REQ-024 RUN, predict_valid=1, no mispredict training: GHR <= {GHR[HIST_BITS-2:0], predict_taken}.
REQ-025 RUN, train_valid=1: PHT[train idx] increments if train_taken=1 and decrements otherwise. The counter saturates at 3 and at 0.
REQ-026 RUN, train_valid=1 and train_mispredicted=1: GHR <= {train_history[HIST_BITS-2:0], train_taken}. This recovery overrides any same-cycle predict update.
REQ-027 Predict and train in the same cycle on the same index: predict_taken reflects the pre-update counter; the write lands at the clock edge.
REQ-028 mispredict_count increments on each RUN cycle with train_valid and train_mispredicted both 1, and holds at 16'hFFFF.
REQ-029 train_mispredicted is ignored when train_valid=0.

Reset
REQ-030 While rst=1, independent of clk: state=INIT, sweep=0, GHR=0, ready=0, mispredict_count=0.
REQ-031 rst asserted mid-INIT or mid-RUN aborts the current operation; the full 2^HIST_BITS sweep restarts after deassertion.
REQ-032 PHT contents are not reset directly; they are defined only after the INIT sweep.

Verification (defaults HIST_BITS=7, PC_BITS=7, CNT_INIT=01)
REQ-033 Release rst, then count cycles -> ready rises exactly 128 cycles later; predict_taken=0 and predict_history=0 throughout.
REQ-034 Predict pc=10, then train pc=10, history=0, taken=1, mispredicted=1 -> predict_taken=0 and predict_history=0 at prediction. Afterwards PHT[10]=2, GHR=7'b0000001, mispredict_count=1.
REQ-035 Continuing REQ-034, predict pc=11 -> idx=10, predict_taken=1, predict_history=7'b0000001; GHR afterwards is 7'b0000011.
REQ-036 Train idx 5 (pc=5, history=0) taken four times -> counter=3. One not-taken training then gives counter=2, and predict_taken is still 1.
REQ-037 Same cycle: predict_valid=1 with predict_taken=1, plus mispredict training with train_history=7'h15 and train_taken=0 -> GHR becomes 7'h2A (train recovery wins).
REQ-038 Assert rst after 50 INIT cycles -> ready stays 0, and rises 128 cycles after the second deassertion.
